// File: rtl/lc_mem_ctrl.sv
// lc_mem_ctrl: memory-side responder for the layer controller MEM interface.
//   Accepts four-phase REQ/ACK read/write requests and services them from an
//   internal word-addressed array; flags out-of-range accesses on MEM_ERR.
// Latency: REQ-high sample edge to ACK-high is ACCESS_LAT+1 edges;
//   worst-case request-to-request is ACCESS_LAT+3 edges.
// Backpressure: one request at a time; REQ is only sampled in IDLE, and
//   ACK/data/err are held until REQ drops.
//
// Ports:
//   CLK, RESET       clock, asynchronous active-high reset
//   MEM_REQ_IN       four-phase request
//   MEM_WRITE        1=write, 0=read (sampled with the request)
//   MEM_ADDR_IN      word address
//   MEM_DATA_IN      write data
//   MEM_PAR_INJ      (LC_MEM_PARITY_EN only) store inverted parity on write
//   MEM_ACK_OUT      acknowledge
//   MEM_DATA_OUT     read data, valid with ACK on a read
//   MEM_ERR          error status of the access being acknowledged
//
// Optional feature: define LC_MEM_PARITY_EN to add a per-word even-parity bit
// checked on reads, plus the MEM_PAR_INJ port.
module lc_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 200,
  parameter int ACCESS_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  MEM_REQ_IN,
  input  logic                  MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] MEM_ADDR_IN,
  input  logic [DATA_WIDTH-1:0] MEM_DATA_IN,
`ifdef LC_MEM_PARITY_EN
  input  logic                  MEM_PAR_INJ,
`endif
  output logic                  MEM_ACK_OUT,
  output logic [DATA_WIDTH-1:0] MEM_DATA_OUT,
  output logic                  MEM_ERR
);

  // One extra bit so DEPTH == 2^ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [3:0]          LP_LAT_M1 = 4'(ACCESS_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ACK
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_ack;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  // Storage is intentionally not reset.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_in_range;
  logic                  w_do_access;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic                  w_rd_err;

  assign w_in_range  = ({1'b0, r_addr} < LP_DEPTH);
  // The access happens on the edge that leaves ACCESS with the counter at 0;
  // a reset before then returns r_state to IDLE and the write never occurs.
  assign w_do_access = (r_state == S_ACCESS) && (r_cnt == 4'd0);
  assign w_mem_we    = w_do_access && r_write && w_in_range;
  assign w_rd_word   = r_mem[r_addr];

`ifdef LC_MEM_PARITY_EN
  logic r_par_inj;
  logic r_par [0:DEPTH-1];

  // Even parity: stored bit makes the total count of ones even.
  assign w_rd_err = (^w_rd_word) ^ r_par[r_addr];

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
      r_par[r_addr] <= (^r_wdata) ^ r_par_inj;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_par_inj <= 1'b0;
    end else if (r_state == S_IDLE && MEM_REQ_IN) begin
      r_par_inj <= MEM_PAR_INJ;
    end
  end
`else
  assign w_rd_err = 1'b0;

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (MEM_REQ_IN) begin
            r_write <= MEM_WRITE;
            r_addr  <= MEM_ADDR_IN;
            r_wdata <= MEM_DATA_IN;
            r_cnt   <= LP_LAT_M1;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // REQ is deliberately ignored here: an early drop still completes.
          if (r_cnt == 4'd0) begin
            r_ack   <= 1'b1;
            r_state <= S_ACK;
            if (!w_in_range) begin
              r_err <= 1'b1;
              if (!r_write) begin
                r_rdata <= '0;
              end
            end else if (!r_write) begin
              r_rdata <= w_rd_word;
              r_err   <= w_rd_err;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ACK: begin
          // Read data is left in place after the handshake completes.
          if (!MEM_REQ_IN) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MEM_ACK_OUT  = r_ack;
  assign MEM_DATA_OUT = r_rdata;
  assign MEM_ERR      = r_err;

endmodule

// File: tb/tb_lc_mem_ctrl.sv
`timescale 1ns/1ps
module tb_lc_mem_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int LAT   = 2;
`ifdef LC_MEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          req   = 1'b0;
  logic          wr    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          err;
`ifdef LC_MEM_PARITY_EN
  logic          par_inj = 1'b0;
`endif

  always #5 clk = ~clk;

  lc_mem_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .ACCESS_LAT(LAT)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .MEM_REQ_IN(req),
    .MEM_WRITE(wr),
    .MEM_ADDR_IN(addr),
    .MEM_DATA_IN(wdata),
`ifdef LC_MEM_PARITY_EN
    .MEM_PAR_INJ(par_inj),
`endif
    .MEM_ACK_OUT(ack),
    .MEM_DATA_OUT(rdata),
    .MEM_ERR(err)
  );

  // Transaction-level model: array contents plus the expected output levels.
  logic [DW-1:0] m_mem   [256];
  bit            m_known [256];
  bit            m_bad   [256];
  logic          exp_ack  = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_err  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Hand-computed literal expectations handed to the compare process.
  int            lit_seq  = 0;
  int            lit_done = 0;
  string         lit_name = "";
  logic          lit_ack  = 1'b0;
  logic [DW-1:0] lit_data = '0;
  logic          lit_err  = 1'b0;
  bit            lit_full = 1'b0;

  always @(negedge clk) begin
    n_tests++;
    if (ack !== exp_ack || rdata !== exp_data || err !== exp_err) begin
      n_fail++;
      $display("FAIL cycle t=%0t ack/data/err got %b/%h/%b required %b/%h/%b",
               $time, ack, rdata, err, exp_ack, exp_data, exp_err);
    end
    if (lit_seq != lit_done) begin
      lit_done = lit_seq;
      n_tests++;
      if (ack !== lit_ack || (lit_full && (rdata !== lit_data || err !== lit_err))) begin
        n_fail++;
        $display("FAIL %s ack/data/err got %b/%h/%b required %b/%h/%b",
                 lit_name, ack, rdata, err, lit_ack, lit_data, lit_err);
      end
    end
  end

  task automatic lit(input string name, input logic a, input logic [DW-1:0] d,
                     input logic e, input bit full);
    lit_name = name;
    lit_ack  = a;
    lit_data = d;
    lit_err  = e;
    lit_full = full;
    lit_seq++;
  endtask

  task automatic scramble();
    addr  = AW'($urandom);
    wdata = DW'($urandom);
    wr    = 1'($urandom);
  endtask

  // Called just after a rising edge. drop_at>0 drops REQ after that edge
  // (protocol violation); otherwise REQ is held 'hold' edges beyond ACK.
  // When pin=1, literal expectations are placed at edges 2 and 3.
  task automatic txn(input bit w, input int a, input logic [DW-1:0] d,
                     input int hold, input int drop_at, input bit inj,
                     input bit pin, input logic [DW-1:0] pin_d, input logic pin_e,
                     input string name);
    logic [DW-1:0] rd;
    logic          er;
    if (w) begin
      rd = exp_data;
      if (a < DEPTH) begin
        m_mem[a] = d; m_known[a] = 1'b1; m_bad[a] = inj; er = 1'b0;
      end else begin
        er = 1'b1;
      end
    end else if (a < DEPTH) begin
      rd = m_mem[a];
      er = m_bad[a] & PAR_ON;
    end else begin
      rd = '0;
      er = 1'b1;
    end
    req = 1'b1; wr = w; addr = a[AW-1:0]; wdata = d;
`ifdef LC_MEM_PARITY_EN
    par_inj = inj;
`endif
    for (int e = 1; e <= LAT + 1; e++) begin
      @(posedge clk); #1;
      if (e == drop_at) req = 1'b0;
      scramble();
      if (e == LAT + 1) begin
        exp_ack = 1'b1; exp_data = rd; exp_err = er;
      end
      if (pin && e == 2) lit({name, "_noack2"}, 1'b0, '0, 1'b0, 1'b0);
      if (pin && e == 3) lit({name, "_ack3"}, 1'b1, pin_d, pin_e, 1'b1);
    end
    if (drop_at == 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        scramble();
      end
      req = 1'b0;
    end
    @(posedge clk); #1;
    exp_ack = 1'b0; exp_err = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a, hold, drop, gap;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    lit("reset", 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Write then read.
    txn(1, 8'h05, 32'hDEADBEEF, 0, 0, 0, 1, 32'h0, 1'b0, "wr05");
    txn(0, 8'h05, 32'h0, 0, 0, 0, 1, 32'hDEADBEEF, 1'b0, "rd05");
    // Range boundary.
    txn(1, 8'hC7, 32'h5A5A0001, 0, 0, 0, 0, 32'h0, 1'b0, "wrC7");
    txn(1, 8'hC8, 32'h11111111, 0, 0, 0, 1, 32'hDEADBEEF, 1'b1, "wrC8");
    txn(0, 8'hC8, 32'h0, 0, 0, 0, 1, 32'h0, 1'b1, "rdC8");
    txn(0, 8'hC7, 32'h0, 0, 0, 0, 1, 32'h5A5A0001, 1'b0, "rdC7");
    // Long hold, then back-to-back write, then early REQ drop.
    txn(0, 8'h05, 32'h0, 10, 0, 0, 1, 32'hDEADBEEF, 1'b0, "hold");
    txn(1, 8'h00, 32'h1, 0, 0, 0, 1, 32'hDEADBEEF, 1'b0, "b2b");
    txn(0, 8'h00, 32'h0, 0, 1, 0, 1, 32'h1, 1'b0, "drop");

    // Reset in the middle of a write.
    txn(1, 8'h10, 32'hAAAAAAAA, 0, 0, 0, 0, 32'h0, 1'b0, "wr10");
    req = 1'b1; wr = 1'b1; addr = 8'h10; wdata = 32'h12345678;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_ack = 1'b0; exp_data = '0; exp_err = 1'b0;
    lit("rst_mid", 1'b0, '0, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    txn(0, 8'h10, 32'h0, 0, 0, 0, 1, 32'hAAAAAAAA, 1'b0, "rd10");

`ifdef LC_MEM_PARITY_EN
    txn(1, 8'h20, 32'h0000000F, 0, 0, 1, 0, 32'h0, 1'b0, "pwr_inj");
    txn(0, 8'h20, 32'h0, 0, 0, 0, 1, 32'h0000000F, 1'b1, "prd_bad");
    txn(1, 8'h20, 32'h0000000F, 0, 0, 0, 0, 32'h0, 1'b0, "pwr_ok");
    txn(0, 8'h20, 32'h0, 0, 0, 0, 1, 32'h0000000F, 1'b0, "prd_ok");
`endif

    // Randomized traffic; reads only target words with known contents.
    for (int i = 0; i < 400; i++) begin
      w = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 255));
      if (w == 0 && a < DEPTH && !m_known[a]) w = 1;
      hold = int'($urandom_range(0, 3));
      drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LAT)) : 0;
      txn(w[0], a, DW'($urandom), hold, drop, 1'($urandom), 0, '0, 1'b0, "rnd");
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; scramble(); end
    end

    @(posedge clk); #1;
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
